// File: rtl/puf_pkg.sv
// Shared definitions for the arbiter-PUF challenge sequencer: challenge width,
// sequencer state encoding and the default LFSR feedback mask.
package puf_pkg;

    localparam int C_LENGTH = 8;

    localparam logic [C_LENGTH-1:0] TAPS_DEFAULT = 8'hB8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_PRE    = 3'd2,
        ST_HIGH   = 3'd3,
        ST_SAMPLE = 3'd4,
        ST_DONE   = 3'd5
    } puf_state_e;

endpackage

// File: rtl/puf_challenge_sequencer_if.sv
// Host and PUF-macro signals of the challenge sequencer; the sequencer is the
// slave, the host side (or a PUF model) is the master.
interface puf_challenge_sequencer_if #(
    parameter int C_LENGTH  = puf_pkg::C_LENGTH,
    parameter int RESP_BITS = 8
);
    logic                 start;
    logic [C_LENGTH-1:0]  seed;
    logic                 busy;
    logic                 done;
    logic [RESP_BITS-1:0] response;
    logic                 unstable;
    logic [C_LENGTH-1:0]  challenge;
    logic                 pulse;
    logic                 puf_resp;

    modport master (
        output start, seed, puf_resp,
        input  busy, done, response, unstable, challenge, pulse
    );

    modport slave (
        input  start, seed, puf_resp,
        output busy, done, response, unstable, challenge, pulse
    );
endinterface

// File: rtl/puf_lfsr.sv
// Fibonacci-style challenge LFSR; a zero seed is forced to 1 so the register
// can never lock up in the all-zero state.
module puf_lfsr #(
    parameter int                  C_LENGTH = puf_pkg::C_LENGTH,
    parameter logic [C_LENGTH-1:0] TAPS     = C_LENGTH'(puf_pkg::TAPS_DEFAULT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [C_LENGTH-1:0] seed,
    input  logic                step,
    output logic [C_LENGTH-1:0] value
);
    logic [C_LENGTH-1:0] lfsr_r;

    function automatic logic [C_LENGTH-1:0] lfsr_next(input logic [C_LENGTH-1:0] cur);
        return {cur[C_LENGTH-2:0], ^(cur & TAPS)};
    endfunction

    // LFSR register: load wins over step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_r <= {C_LENGTH{1'b0}};
        end else if (load) begin
            lfsr_r <= (seed == {C_LENGTH{1'b0}}) ? {{(C_LENGTH-1){1'b0}}, 1'b1} : seed;
        end else if (step) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign value = lfsr_r;
endmodule

// File: rtl/puf_challenge_sequencer.sv
// Drives challenges and excitation pulses into the arbiter PUF, majority-votes
// repeated evaluations and assembles the voted bits into a response word.
module puf_challenge_sequencer #(
    parameter int                  C_LENGTH  = puf_pkg::C_LENGTH,
    parameter int                  RESP_BITS = 8,
    parameter int                  VOTES     = 3,
    parameter int                  SETTLE    = 4,
    parameter logic [C_LENGTH-1:0] TAPS      = C_LENGTH'(puf_pkg::TAPS_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     rst,
    puf_challenge_sequencer_if.slave bus
);
    import puf_pkg::*;

    localparam int PW = $clog2(SETTLE) + 1;
    localparam int VW = $clog2(VOTES) + 1;
    localparam int BW = $clog2(RESP_BITS) + 1;

    puf_state_e           state_r, state_nxt_s;
    logic [PW-1:0]        phase_r;
    logic [VW-1:0]        vote_r, ones_r, ones_sum_s;
    logic [BW-1:0]        bit_r;
    logic [RESP_BITS-2:0] shift_r;
    logic [RESP_BITS-1:0] shift_nxt_s;
    logic                 sticky_r, sticky_nxt_s;
    logic                 sync1_r, sync2_r;
    logic                 busy_r, done_r, pulse_r, unstable_r;
    logic [RESP_BITS-1:0] response_r;
    logic                 busy_nxt_s, pulse_nxt_s;
    logic                 lfsr_load_s, lfsr_step_s;
    logic                 phase_last_s, vote_last_s, bit_last_s;
    logic                 voted_s, split_s;
    logic [C_LENGTH-1:0]  lfsr_value_s;

    puf_lfsr #(.C_LENGTH(C_LENGTH), .TAPS(TAPS)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load_s),
        .seed  (bus.seed),
        .step  (lfsr_step_s),
        .value (lfsr_value_s)
    );

    assign phase_last_s = (phase_r == PW'(SETTLE - 1));
    assign vote_last_s  = (vote_r == VW'(VOTES - 1));
    assign bit_last_s   = (bit_r == BW'(RESP_BITS - 1));
    assign ones_sum_s   = ones_r + VW'(sync2_r);
    assign voted_s      = (ones_sum_s > VW'(VOTES / 2));
    assign split_s      = (ones_sum_s != VW'(0)) && (ones_sum_s != VW'(VOTES));
    // The shift register keeps only RESP_BITS-1 bits: the newest bit joins at DONE.
    assign shift_nxt_s  = {voted_s, shift_r};
    assign sticky_nxt_s = sticky_r | split_s;

    // Two-flop synchronizer for the asynchronous arbiter output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= bus.puf_resp;
            sync2_r <= sync1_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode, LFSR control and next values of the registered outputs
    always_comb begin
        state_nxt_s = state_r;
        lfsr_load_s = 1'b0;
        lfsr_step_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt_s = ST_LOAD;
                    lfsr_load_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD:   state_nxt_s = ST_PRE;
            ST_PRE:    state_nxt_s = phase_last_s ? ST_HIGH : ST_PRE;
            ST_HIGH:   state_nxt_s = phase_last_s ? ST_SAMPLE : ST_HIGH;
            ST_SAMPLE: begin
                if (vote_last_s) begin
                    lfsr_step_s = 1'b1;
                    state_nxt_s = bit_last_s ? ST_DONE : ST_PRE;
                end else begin
                    state_nxt_s = ST_PRE;
                end
            end
            ST_DONE:   state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
        busy_nxt_s  = state_nxt_s inside {ST_LOAD, ST_PRE, ST_HIGH, ST_SAMPLE};
        pulse_nxt_s = state_nxt_s inside {ST_HIGH, ST_SAMPLE};
    end

    // Phase/vote/bit counters, vote accumulation and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_r    <= PW'(0);
            vote_r     <= VW'(0);
            ones_r     <= VW'(0);
            bit_r      <= BW'(0);
            shift_r    <= {(RESP_BITS-1){1'b0}};
            sticky_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pulse_r    <= 1'b0;
            response_r <= {RESP_BITS{1'b0}};
            unstable_r <= 1'b0;
        end else begin
            busy_r  <= busy_nxt_s;
            pulse_r <= pulse_nxt_s;
            done_r  <= (state_nxt_s == ST_DONE);
            case (state_r)
                ST_LOAD: begin
                    phase_r  <= PW'(0);
                    vote_r   <= VW'(0);
                    ones_r   <= VW'(0);
                    bit_r    <= BW'(0);
                    sticky_r <= 1'b0;
                end
                ST_PRE, ST_HIGH: begin
                    phase_r <= phase_last_s ? PW'(0) : phase_r + PW'(1);
                end
                ST_SAMPLE: begin
                    phase_r <= PW'(0);
                    if (vote_last_s) begin
                        vote_r   <= VW'(0);
                        ones_r   <= VW'(0);
                        bit_r    <= bit_r + BW'(1);
                        shift_r  <= shift_nxt_s[RESP_BITS-1:1];
                        sticky_r <= sticky_nxt_s;
                    end else begin
                        vote_r <= vote_r + VW'(1);
                        ones_r <= ones_sum_s;
                    end
                end
                default: begin
                    phase_r <= phase_r;
                end
            endcase
            if (state_nxt_s == ST_DONE) begin
                response_r <= shift_nxt_s;
                unstable_r <= sticky_nxt_s;
            end else begin
                response_r <= response_r;
                unstable_r <= unstable_r;
            end
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pulse     = pulse_r;
    assign bus.response  = response_r;
    assign bus.unstable  = unstable_r;
    assign bus.challenge = lfsr_value_s;
endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Directed bench for puf_challenge_sequencer with a small behavioural PUF model.
module tb_puf_challenge_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    puf_challenge_sequencer_if #(.C_LENGTH(8), .RESP_BITS(8)) bus ();

    puf_challenge_sequencer #(
        .C_LENGTH(8), .RESP_BITS(8), .VOTES(3), .SETTLE(4), .TAPS(8'hB8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // PUF model: 0 = tied low, 1 = tied high, 2 = challenge[0], 3 = 1,0,1 per evaluation
    int mode      = 0;
    int eval_n    = 0;
    int eval_base = 0;

    always @(negedge bus.pulse) eval_n <= eval_n + 1;

    always_comb begin
        case (mode)
            1:       bus.puf_resp = 1'b1;
            2:       bus.puf_resp = bus.challenge[0];
            3:       bus.puf_resp = (((eval_n - eval_base) % 3) != 1);
            default: bus.puf_resp = 1'b0;
        endcase
    end

    logic [7:0] trace [16];
    int         trace_n;
    int         stab_err;
    int         lat;
    logic [7:0] resp_o;
    logic       unst_o;

    localparam logic [7:0] TRACE_S01 [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
    localparam logic [7:0] TRACE_S8E [8] = '{8'h8E, 8'h1C, 8'h38, 8'h71, 8'hE2, 8'hC4, 8'h89, 8'h12};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // One response word; lat is the cycle index of done, where LOAD is cycle 1.
    task automatic run_word(input logic [7:0] sd, input int md, input bit retrig);
        int         cyc;
        bit         seen;
        logic [7:0] prev;
        mode      = md;
        eval_base = eval_n;
        trace_n   = 0;
        stab_err  = 0;
        lat       = 0;
        @(negedge clk);
        bus.seed  = sd;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.seed  = 8'hA5;
        cyc  = 1;
        seen = 1'b0;
        check_val("load_busy", 32'(bus.busy), 32'd1);
        prev       = bus.challenge;
        trace[0]   = prev;
        trace_n    = 1;
        while (!seen && cyc < 400) begin
            bus.start = (retrig && cyc == 50) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            cyc++;
            if (bus.pulse && bus.challenge != prev) stab_err++;
            if (bus.busy && bus.challenge != prev && trace_n < 16) begin
                trace[trace_n] = bus.challenge;
                trace_n++;
            end
            prev = bus.challenge;
            if (bus.done) begin
                seen = 1'b1;
                lat  = cyc;
            end
        end
        check_val("done_seen", 32'(seen), 32'd1);
        resp_o = bus.response;
        unst_o = bus.unstable;
        // start during DONE must be dropped, not queued
        bus.start = retrig;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check_val("done_one_cycle", 32'(bus.done), 32'd0);
        check_val("after_done_busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        check_val("start_in_done_ignored", 32'(bus.busy), 32'd0);
    endtask

    task automatic check_trace(input string tag, input logic [7:0] exp_tr [8]);
        check_val({tag, "_len"}, 32'(trace_n), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("%s_%0d", tag, i), 32'(trace[i]), 32'(exp_tr[i]));
        end
    endtask

    initial begin
        int hits;
        bus.start = 1'b0;
        bus.seed  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("rst_busy",      32'(bus.busy),      32'd0);
        check_val("rst_done",      32'(bus.done),      32'd0);
        check_val("rst_response",  32'(bus.response),  32'd0);
        check_val("rst_unstable",  32'(bus.unstable),  32'd0);
        check_val("rst_challenge", 32'(bus.challenge), 32'd0);
        check_val("rst_pulse",     32'(bus.pulse),     32'd0);

        hits = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (bus.busy || bus.done) hits++;
        end
        check_val("idle_quiet", 32'(hits), 32'd0);

        // Tied-high PUF, with start re-asserted mid-run
        run_word(8'h01, 1, 1'b1);
        check_val("tie1_latency",  32'(lat),    32'd218);
        check_val("tie1_response", 32'(resp_o), 32'hFF);
        check_val("tie1_unstable", 32'(unst_o), 32'd0);

        // Behavioural PUF, response = challenge[0]
        run_word(8'h01, 2, 1'b0);
        check_val("chal_latency",  32'(lat),      32'd218);
        check_val("chal_response", 32'(resp_o),   32'h71);
        check_val("chal_unstable", 32'(unst_o),   32'd0);
        check_val("chal_stable",   32'(stab_err), 32'd0);
        check_trace("chal_trace", TRACE_S01);

        // Zero seed behaves as seed 1
        run_word(8'h00, 2, 1'b0);
        check_val("seed0_response", 32'(resp_o),   32'h71);
        check_val("seed0_unstable", 32'(unst_o),   32'd0);
        check_val("seed0_stable",   32'(stab_err), 32'd0);
        check_trace("seed0_trace", TRACE_S01);

        // Votes 1,0,1 for every bit
        run_word(8'h01, 3, 1'b0);
        check_val("tog_response", 32'(resp_o), 32'hFF);
        check_val("tog_unstable", 32'(unst_o), 32'd1);

        // Reset in the middle of a run while pulse is high
        mode = 1;
        @(negedge clk);
        bus.seed  = 8'h01;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        hits = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (i >= 60 && bus.pulse) break;
        end
        check_val("abort_busy_before", 32'(bus.busy),  32'd1);
        check_val("abort_pulse_before", 32'(bus.pulse), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("abort_pulse",     32'(bus.pulse),     32'd0);
        check_val("abort_busy",      32'(bus.busy),      32'd0);
        check_val("abort_done",      32'(bus.done),      32'd0);
        check_val("abort_response",  32'(bus.response),  32'd0);
        check_val("abort_unstable",  32'(bus.unstable),  32'd0);
        check_val("abort_challenge", 32'(bus.challenge), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) hits++;
        end
        check_val("abort_no_done", 32'(hits), 32'd0);

        // A fresh run after the abort completes normally
        run_word(8'h8E, 2, 1'b0);
        check_val("rerun_latency",  32'(lat),      32'd218);
        check_val("rerun_response", 32'(resp_o),   32'h48);
        check_val("rerun_unstable", 32'(unst_o),   32'd0);
        check_val("rerun_stable",   32'(stab_err), 32'd0);
        check_trace("rerun_trace", TRACE_S8E);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
